axi_slave_fsm: RTL and testbench

- AXI-style responder that terminates the transactions issued by the team's AXI master FSM.
- Owns a small 32-bit register bank.
- Accepts single-beat writes on the AW/W channels and answers on B.
- Accepts incrementing read bursts on AR (4-bit beat length) and answers on R.
- Write and read paths are independent FSMs, so one write and one read may be in flight at the same time.

---
 rtl/axi_slave_pkg.sv | 35 +++
 rtl/axi_slave_regfile.sv | 36 +++
 rtl/axi_slave_fsm.sv | 235 +++++++++++++++++++++++
 tb/tb_axi_slave_fsm.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI-style register-bank responder.
package axi_slave_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'b01,
        W_RESP = 2'b10
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'b01,
        R_DATA = 2'b10
    } r_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_req_t;

    // A byte address hits the bank only below NUM_REGS words.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       num_regs);
        return addr < ADDR_W'(num_regs * 4);
    endfunction

endpackage

// File: rtl/axi_slave_regfile.sv
// Register bank: one byte-enabled write port, one combinational read port.
module axi_slave_regfile
    import axi_slave_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] be,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (be[b]) begin
                    mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata_c = mem_q[ridx];

endmodule

// File: rtl/axi_slave_fsm.sv
// AXI-style responder: single-beat writes on AW/W/B, incrementing read bursts on AR/R.
// Define AXI_SLAVE_WSTRB_EN to honour M_WSTRB; otherwise every write stores all four bytes.
module axi_slave_fsm
    import axi_slave_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_LSB = 2
) (
    input  logic              S_ACLK,
    input  logic              S_ARESET_N,
    input  logic              M_AWVALID,
    input  logic [ADDR_W-1:0] M_AWADDR,
    output logic              S_AWREADY,
    input  logic              M_WVALID,
    input  logic [DATA_W-1:0] M_WDATA,
    input  logic [STRB_W-1:0] M_WSTRB,
    output logic              S_WREADY,
    output logic              S_BVALID,
    output logic [RESP_W-1:0] S_BRESP,
    input  logic              M_BREADY,
    input  logic              M_ARVALID,
    input  logic [ADDR_W-1:0] M_ARADDR,
    input  logic [LEN_W-1:0]  M_BLEN,
    output logic              S_ARREADY,
    output logic              S_RVALID,
    output logic [DATA_W-1:0] S_RDATA,
    output logic [RESP_W-1:0] S_RRESP,
    output logic              S_RLAST,
    input  logic              M_RREADY
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    w_state_e          w_state_q, w_state_d;
    logic              aw_have_q, aw_have_d;
    logic              w_have_q, w_have_d;
    wr_req_t           wreq_q, wreq_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [RESP_W-1:0] bresp_q, bresp_d;

    r_state_e          r_state_q, r_state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [LEN_W-1:0]  rcnt_q, rcnt_d;
    logic [LEN_W-1:0]  rlen_q, rlen_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [RESP_W-1:0] rresp_q, rresp_d;
    logic              rlast_q, rlast_d;

    logic              rf_we;
    logic [STRB_W-1:0] rf_be;
    logic [IDX_W-1:0]  rf_widx;
    logic [IDX_W-1:0]  rf_ridx;
    logic [DATA_W-1:0] rf_rdata_c;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              rd_load;
    logic              rd_done;

`ifdef AXI_SLAVE_WSTRB_EN
    assign rf_be = wreq_q.strb;
`else
    assign rf_be = {STRB_W{1'b1}};
    logic unused_strb;
    assign unused_strb = ^wreq_q.strb;
`endif

    assign wr_in_range = addr_in_range(wreq_q.addr, NUM_REGS);
    assign rf_widx     = wreq_q.addr[ADDR_LSB +: IDX_W];

    axi_slave_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk     (S_ACLK),
        .rst_n   (S_ARESET_N),
        .we      (rf_we),
        .widx    (rf_widx),
        .wdata   (wreq_q.data),
        .be      (rf_be),
        .ridx    (rf_ridx),
        .rdata_c (rf_rdata_c)
    );

    // Write path: capture AW and W independently, commit one cycle after both are held.
    always_comb begin
        w_state_d = w_state_q;
        aw_have_d = aw_have_q;
        w_have_d  = w_have_q;
        wreq_d    = wreq_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rf_we     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_have_q && w_have_q) begin
                    rf_we     = wr_in_range;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    w_state_d = W_RESP;
                end else begin
                    if (M_AWVALID && awready_q) begin
                        aw_have_d   = 1'b1;
                        wreq_d.addr = M_AWADDR;
                    end
                    if (M_WVALID && wready_q) begin
                        w_have_d    = 1'b1;
                        wreq_d.data = M_WDATA;
                        wreq_d.strb = M_WSTRB;
                    end
                end
            end
            W_RESP: begin
                if (M_BREADY) begin
                    bvalid_d  = 1'b0;
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_have_d;
        wready_d  = (w_state_d == W_IDLE) && !w_have_d;
    end

    // Read path sequencing: address and beat counter for the next presented beat.
    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rcnt_d    = rcnt_q;
        rlen_d    = rlen_q;
        rd_load   = 1'b0;
        rd_done   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (M_ARVALID && arready_q) begin
                    raddr_d   = M_ARADDR;
                    rlen_d    = M_BLEN;
                    rcnt_d    = '0;
                    rd_load   = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (M_RREADY) begin
                    if (rcnt_q == rlen_q) begin
                        rd_done   = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        raddr_d = raddr_q + ADDR_W'(4);
                        rcnt_d  = rcnt_q + LEN_W'(1);
                        rd_load = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign rf_ridx     = raddr_d[ADDR_LSB +: IDX_W];
    assign rd_in_range = addr_in_range(raddr_d, NUM_REGS);

    // Beat payload is sampled once per beat, so a same-edge write commit is seen on the next beat.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        if (rd_load) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_in_range ? rf_rdata_c : '0;
            rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
            rlast_d  = (rcnt_d == rlen_d);
        end else if (rd_done) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
        end
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge S_ACLK or negedge S_ARESET_N) begin
        if (!S_ARESET_N) begin
            w_state_q <= W_IDLE;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            wreq_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rcnt_q    <= '0;
            rlen_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            wreq_q    <= wreq_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rcnt_q    <= rcnt_d;
            rlen_q    <= rlen_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign S_AWREADY = awready_q;
    assign S_WREADY  = wready_q;
    assign S_BVALID  = bvalid_q;
    assign S_BRESP   = bresp_q;
    assign S_ARREADY = arready_q;
    assign S_RVALID  = rvalid_q;
    assign S_RDATA   = rdata_q;
    assign S_RRESP   = rresp_q;
    assign S_RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_slave_fsm.sv
// Directed bench for axi_slave_fsm with a transaction-level model checked every cycle.
module tb_axi_slave_fsm;

    localparam int NUM_REGS = 16;
    localparam int BOUND    = 64;

`ifdef AXI_SLAVE_WSTRB_EN
    localparam logic [31:0] EXP_STRB = 32'hAA22_CC44;
    localparam logic [31:0] EXP_ZERO = 32'h0000_0013;
`else
    localparam logic [31:0] EXP_STRB = 32'h1122_3344;
    localparam logic [31:0] EXP_ZERO = 32'h5555_5555;
`endif

    logic        clk = 1'b0;
    logic        S_ARESET_N;
    logic        M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR;
    logic [3:0]  M_WSTRB, M_BLEN;
    logic        S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID, S_RLAST;
    logic [1:0]  S_BRESP, S_RRESP;
    logic [31:0] S_RDATA;

    int errors = 0;
    int checks = 0;

    axi_slave_fsm #(.NUM_REGS(NUM_REGS), .ADDR_LSB(2)) dut (
        .S_ACLK(clk), .S_ARESET_N(S_ARESET_N),
        .M_AWVALID(M_AWVALID), .M_AWADDR(M_AWADDR), .S_AWREADY(S_AWREADY),
        .M_WVALID(M_WVALID), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .S_WREADY(S_WREADY),
        .S_BVALID(S_BVALID), .S_BRESP(S_BRESP), .M_BREADY(M_BREADY),
        .M_ARVALID(M_ARVALID), .M_ARADDR(M_ARADDR), .M_BLEN(M_BLEN), .S_ARREADY(S_ARREADY),
        .S_RVALID(S_RVALID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
        .M_RREADY(M_RREADY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [NUM_REGS];
    logic        m_awrdy, m_wrdy, m_arrdy, m_bvalid, m_rvalid, m_rlast;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata, m_waddr, m_wdata, m_raddr;
    logic [3:0]  m_wstrb;
    logic        m_aw_have, m_w_have;
    int          m_rbeat, m_rbeats;

    function automatic logic in_rng(input logic [31:0] a);
        return a < 32'(NUM_REGS * 4);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_mem[i] = '0;
        m_awrdy = 0; m_wrdy = 0; m_arrdy = 0; m_bvalid = 0; m_rvalid = 0; m_rlast = 0;
        m_bresp = 0; m_rresp = 0; m_rdata = 0; m_aw_have = 0; m_w_have = 0;
        m_waddr = 0; m_wdata = 0; m_wstrb = 0; m_raddr = 0; m_rbeat = 0; m_rbeats = 0;
    endtask

    task automatic load_beat();
        if (in_rng(m_raddr)) begin
            m_rdata = m_mem[int'(m_raddr >> 2)];
            m_rresp = 2'b00;
        end else begin
            m_rdata = 0;
            m_rresp = 2'b10;
        end
        m_rlast = (m_rbeat == m_rbeats - 1);
    endtask

    // Advances the model across the coming rising edge using the inputs now applied.
    task automatic model_update();
        logic aw_hs, w_hs, ar_hs;
        logic [3:0] be;
        aw_hs = M_AWVALID && m_awrdy;
        w_hs  = M_WVALID && m_wrdy;
        ar_hs = M_ARVALID && m_arrdy;
        if (m_rvalid) begin
            if (M_RREADY) begin
                if (m_rbeat == m_rbeats - 1) begin
                    m_rvalid = 0;
                    m_rlast  = 0;
                end else begin
                    m_rbeat++;
                    m_raddr = m_raddr + 32'd4;
                    load_beat();
                end
            end
        end else if (ar_hs) begin
            m_raddr  = M_ARADDR;
            m_rbeats = int'(M_BLEN) + 1;
            m_rbeat  = 0;
            m_rvalid = 1;
            load_beat();
        end
        m_arrdy = !m_rvalid;
        if (m_bvalid) begin
            if (M_BREADY) begin
                m_bvalid = 0; m_aw_have = 0; m_w_have = 0;
            end
        end else if (m_aw_have && m_w_have) begin
`ifdef AXI_SLAVE_WSTRB_EN
            be = m_wstrb;
`else
            be = 4'hF;
`endif
            if (in_rng(m_waddr)) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_mem[int'(m_waddr >> 2)][8*b +: 8] = m_wdata[8*b +: 8];
                m_bresp = 2'b00;
            end else begin
                m_bresp = 2'b10;
            end
            m_bvalid = 1;
        end else begin
            if (aw_hs) begin m_aw_have = 1; m_waddr = M_AWADDR; end
            if (w_hs)  begin m_w_have = 1; m_wdata = M_WDATA; m_wstrb = M_WSTRB; end
        end
        m_awrdy = !m_bvalid && !m_aw_have;
        m_wrdy  = !m_bvalid && !m_w_have;
    endtask

    task automatic compare();
        chk("cyc_awready", 32'(S_AWREADY), 32'(m_awrdy));
        chk("cyc_wready",  32'(S_WREADY),  32'(m_wrdy));
        chk("cyc_arready", 32'(S_ARREADY), 32'(m_arrdy));
        chk("cyc_bvalid",  32'(S_BVALID),  32'(m_bvalid));
        chk("cyc_rvalid",  32'(S_RVALID),  32'(m_rvalid));
        if (m_bvalid) chk("cyc_bresp", 32'(S_BRESP), 32'(m_bresp));
        if (m_rvalid) begin
            chk("cyc_rdata", S_RDATA, m_rdata);
            chk("cyc_rresp", 32'(S_RRESP), 32'(m_rresp));
            chk("cyc_rlast", 32'(S_RLAST), 32'(m_rlast));
        end
        if (!S_ARESET_N) begin
            chk("rst_bresp", 32'(S_BRESP), 32'd0);
            chk("rst_rdata", S_RDATA, 32'd0);
            chk("rst_rresp", 32'(S_RRESP), 32'd0);
            chk("rst_rlast", 32'(S_RLAST), 32'd0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!S_ARESET_N) model_reset();
            compare();
            if (S_ARESET_N) model_update();
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] got_data [16];
    logic [1:0]  got_resp [16];
    logic        got_last [16];

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr_phase(input logic do_aw, input logic do_w, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        logic a, w;
        M_AWVALID = do_aw; M_AWADDR = addr;
        M_WVALID  = do_w;  M_WDATA = data; M_WSTRB = strb;
        for (int k = 0; k < BOUND && (M_AWVALID || M_WVALID); k++) begin
            a = M_AWVALID && S_AWREADY;
            w = M_WVALID && S_WREADY;
            step();
            if (a) M_AWVALID = 0;
            if (w) M_WVALID = 0;
        end
        if (M_AWVALID || M_WVALID) begin
            chk("wr_hs_timeout", 32'd1, 32'd0);
            M_AWVALID = 0; M_WVALID = 0;
        end
    endtask

    task automatic wait_b(input int hold, output int lat, output logic [1:0] resp);
        logic acc;
        int k;
        acc = 0; lat = -1; resp = 2'b11; k = 0; M_BREADY = 0;
        while (k < BOUND) begin
            if (S_BVALID && lat < 0) begin lat = k; resp = S_BRESP; end
            if (lat >= 0 && k - lat >= hold) M_BREADY = 1;
            acc = S_BVALID && M_BREADY;
            step();
            k++;
            if (acc) break;
        end
        M_BREADY = 0;
        if (!acc) chk("b_timeout", 32'd1, 32'd0);
    endtask

    task automatic write(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output logic [1:0] resp);
        int lat;
        wr_phase(1, 1, addr, data, strb);
        wait_b(0, lat, resp);
    endtask

    task automatic ar_phase(input logic [31:0] addr, input logic [3:0] len);
        logic a;
        a = 0;
        M_ARVALID = 1; M_ARADDR = addr; M_BLEN = len;
        for (int k = 0; k < BOUND; k++) begin
            a = S_ARREADY;
            step();
            if (a) break;
        end
        M_ARVALID = 0;
        if (!a) chk("ar_timeout", 32'd1, 32'd0);
    endtask

    task automatic rd_burst(input logic [31:0] addr, input logic [3:0] len,
                            input logic [15:0] pat, input int npat, output int nb);
        logic acc, last;
        int k, i;
        nb = 0; k = 0; i = 0; acc = 0; last = 0;
        ar_phase(addr, len);
        while (k < BOUND) begin
            M_RREADY = (i < npat) ? pat[i] : 1'b1;
            i++;
            acc = S_RVALID && M_RREADY;
            last = 0;
            if (acc && nb < 16) begin
                got_data[nb] = S_RDATA; got_resp[nb] = S_RRESP; got_last[nb] = S_RLAST;
                last = S_RLAST;
                nb++;
            end
            step();
            k++;
            if (acc && last) break;
        end
        M_RREADY = 0;
        if (!(acc && last)) chk("r_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int lat, nb;
        logic [1:0] resp;
        S_ARESET_N = 0;
        M_AWVALID = 0; M_WVALID = 0; M_BREADY = 0; M_ARVALID = 0; M_RREADY = 0;
        M_AWADDR = 0; M_WDATA = 0; M_WSTRB = 0; M_ARADDR = 0; M_BLEN = 0;
        repeat (3) step();
        chk("rst_readys", 32'({S_AWREADY, S_WREADY, S_ARREADY}), 32'd0);
        chk("rst_valids", 32'({S_BVALID, S_RVALID}), 32'd0);
        S_ARESET_N = 1;
        step();
        chk("readys_after_rst", 32'({S_AWREADY, S_WREADY, S_ARREADY}), 32'b111);

        // Same-cycle AW/W, then single-beat read back
        wr_phase(1, 1, 32'h08, 32'hDEAD_BEEF, 4'hF);
        wait_b(0, lat, resp);
        chk("t1_b_latency", 32'(lat), 32'd1);
        chk("t1_bresp", 32'(resp), 32'd0);
        rd_burst(32'h08, 4'd0, 16'h0, 0, nb);
        chk("t1_beats", 32'(nb), 32'd1);
        chk("t1_rdata", got_data[0], 32'hDEAD_BEEF);
        chk("t1_rlast", 32'(got_last[0]), 32'd1);
        chk("t1_rresp", 32'(got_resp[0]), 32'd0);

        // W three cycles ahead of AW, BREADY held off
        wr_phase(0, 1, 32'h04, 32'h1234_5678, 4'hF);
        repeat (2) step();
        wr_phase(1, 0, 32'h04, 32'h1234_5678, 4'hF);
        wait_b(4, lat, resp);
        chk("t2_b_latency", 32'(lat), 32'd1);
        chk("t2_bresp", 32'(resp), 32'd0);
        rd_burst(32'h04, 4'd0, 16'h0, 0, nb);
        chk("t2_rdata", got_data[0], 32'h1234_5678);

        // Burst with a stall
        for (int r = 0; r < 4; r++) write(32'(4 * r), 32'h10 + 32'(r), 4'hF, resp);
        rd_burst(32'h00, 4'd3, 16'h001D, 5, nb);
        chk("t3_beats", 32'(nb), 32'd4);
        for (int b = 0; b < 4; b++) begin
            chk("t3_rdata", got_data[b], 32'h10 + 32'(b));
            chk("t3_rlast", 32'(got_last[b]), 32'(b == 3));
        end

        // Burst crossing the top of the bank, then an out-of-range write
        write(32'h3C, 32'hCAFE_F00D, 4'hF, resp);
        rd_burst(32'h3C, 4'd1, 16'h0, 0, nb);
        chk("t4_b0_data", got_data[0], 32'hCAFE_F00D);
        chk("t4_b0_resp", 32'(got_resp[0]), 32'd0);
        chk("t4_b0_last", 32'(got_last[0]), 32'd0);
        chk("t4_b1_data", got_data[1], 32'd0);
        chk("t4_b1_resp", 32'(got_resp[1]), 32'b10);
        chk("t4_b1_last", 32'(got_last[1]), 32'd1);
        write(32'h40, 32'h0BAD_0BAD, 4'hF, resp);
        chk("t4_oor_bresp", 32'(resp), 32'b10);
        rd_burst(32'h00, 4'd0, 16'h0, 0, nb);
        chk("t4_no_alias", got_data[0], 32'h10);

        // Byte strobes
        write(32'h08, 32'hAABB_CCDD, 4'hF, resp);
        write(32'h08, 32'h1122_3344, 4'b0101, resp);
        rd_burst(32'h08, 4'd0, 16'h0, 0, nb);
        chk("t5_strb_data", got_data[0], EXP_STRB);
        chk("t5_model_pin", m_mem[2], EXP_STRB);
        write(32'h0C, 32'h5555_5555, 4'b0000, resp);
        chk("t5_zero_bresp", 32'(resp), 32'd0);
        rd_burst(32'h0C, 4'd0, 16'h0, 0, nb);
        chk("t5_zero_data", got_data[0], EXP_ZERO);

        // Maximum burst length
        rd_burst(32'h00, 4'd15, 16'h0, 0, nb);
        chk("t6_beats", 32'(nb), 32'd16);
        chk("t6_first", got_data[0], 32'h10);
        chk("t6_last_data", got_data[15], 32'hCAFE_F00D);
        chk("t6_last14", 32'(got_last[14]), 32'd0);
        chk("t6_last15", 32'(got_last[15]), 32'd1);

        // Concurrent write and read of the same register
        fork
            write(32'h10, 32'h0000_0044, 4'hF, resp);
            rd_burst(32'h10, 4'd0, 16'h0, 0, nb);
        join
        chk("t7_old_value", got_data[0], 32'd0);
        rd_burst(32'h10, 4'd0, 16'h0, 0, nb);
        chk("t7_new_value", got_data[0], 32'h44);

        // Reset mid-burst with a write response pending
        wr_phase(1, 1, 32'h00, 32'h99, 4'hF);
        ar_phase(32'h00, 4'd3);
        M_RREADY = 1;
        repeat (2) step();
        chk("t8_pre_bvalid", 32'(S_BVALID), 32'd1);
        chk("t8_pre_rvalid", 32'(S_RVALID), 32'd1);
        S_ARESET_N = 0; M_RREADY = 0; M_BREADY = 0;
        #1;
        chk("t8_rst_bvalid", 32'(S_BVALID), 32'd0);
        chk("t8_rst_rvalid", 32'(S_RVALID), 32'd0);
        repeat (2) step();
        S_ARESET_N = 1;
        repeat (2) step();
        rd_burst(32'h00, 4'd0, 16'h0, 0, nb);
        chk("t8_reg0_cleared", got_data[0], 32'd0);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
